// File: rtl/logic_seq_if.sv
// logic_seq_if: operand/op request, status and 1-bit logic unit bus (LOGSEQ_ZFLAG_EN adds zero)
interface logic_seq_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [1:0]       op;
   logic             lu_a;
   logic             lu_b;
   logic [1:0]       lu_control;
   logic             lu_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef LOGSEQ_ZFLAG_EN
   logic             zero;
   modport master (output start, A, B, op, lu_out,
                   input lu_a, lu_b, lu_control, busy, done, result, zero);
   modport slave  (input start, A, B, op, lu_out,
                   output lu_a, lu_b, lu_control, busy, done, result, zero);
`else
   modport master (output start, A, B, op, lu_out,
                   input lu_a, lu_b, lu_control, busy, done, result);
   modport slave  (input start, A, B, op, lu_out,
                   output lu_a, lu_b, lu_control, busy, done, result);
`endif
endinterface

// File: rtl/logic_seq_ctrl.sv
// logic_seq_ctrl: bit-serial LSB-first sequencer for a shared 1-bit logic unit (LOGSEQ_ZFLAG_EN adds zero flag)
module logic_seq_ctrl #(parameter int WIDTH = 8) (
   input logic        clk,
   input logic        reset,
   logic_seq_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] sa, sb, acc, result_r;
   logic [1:0]       op_r;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc_next;
   assign acc_next       = {bus.lu_out, acc[WIDTH-1:1]};
   assign bus.busy       = state == RUN;
   assign bus.done       = state == DONE;
   assign bus.result     = result_r;
   assign bus.lu_a       = (state == RUN) & sa[0];
   assign bus.lu_b       = (state == RUN) & sb[0];
   assign bus.lu_control = state == RUN ? op_r : 2'b00;
`ifdef LOGSEQ_ZFLAG_EN
   logic zero_r;
   assign bus.zero = zero_r;
   // zero flag loads only together with result so the two never disagree
   always_ff @(posedge clk)
      if (reset)
         zero_r <= 1'b0;
      else if (state == RUN && cnt == LAST)
         zero_r <= acc_next == '0;
`endif
   // sequencer: capture on start from IDLE/DONE, stream one bit per cycle, publish whole result at the end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         acc      <= '0;
         op_r     <= 2'b00;
         cnt      <= '0;
         result_r <= '0;
      end else begin
         case (state)
            RUN: begin
               acc <= acc_next;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) begin
                  result_r <= acc_next;
                  state    <= DONE;
               end
            end
            default: begin
               state <= bus.start ? RUN : IDLE;
               if (bus.start) begin
                  sa   <= bus.A;
                  sb   <= bus.B;
                  op_r <= bus.op;
                  cnt  <= '0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_logic_seq_ctrl.sv
// tb_logic_seq_ctrl: scoreboard bench for logic_seq_ctrl with a golden 1-bit logic unit
module tb_logic_seq_ctrl;
   localparam int W = 8;
   typedef struct {
      logic [W-1:0] res;
      int           due;
   } exp_t;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   logic [W-1:0] exp_hold = '0;
   exp_t         q[$];
   exp_t         e;

   logic_seq_if #(.WIDTH(W)) bus();
   logic_seq_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // golden external logic unit
   always_comb
      bus.lu_out = bus.lu_control == 2'b00 ? (bus.lu_a & bus.lu_b) :
                   bus.lu_control == 2'b01 ? (bus.lu_a | bus.lu_b) :
                   bus.lu_control == 2'b10 ? ~(bus.lu_a | bus.lu_b) : (bus.lu_a ^ bus.lu_b);

   function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] o);
      case (o)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return ~(a | b);
         default: return a ^ b;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pops the scoreboard on done, otherwise checks that status and result hold
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!reset) begin
         chk("busy", 32'(bus.busy), 32'(q.size() > 0 && cyc >= q[0].due - W && cyc < q[0].due));
         if (!bus.busy)
            chk("lu_idle", {28'd0, bus.lu_a, bus.lu_b, bus.lu_control}, 32'd0);
         if (bus.done) begin
            if (q.size() == 0)
               chk("done_unexpected", 32'(bus.done), 32'd0);
            else begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.due);
               chk("result", 32'(bus.result), 32'(e.res));
`ifdef LOGSEQ_ZFLAG_EN
               chk("zero", 32'(bus.zero), 32'(e.res == '0));
`endif
               exp_hold = e.res;
            end
         end else begin
            chk("result_hold", 32'(bus.result), 32'(exp_hold));
`ifdef LOGSEQ_ZFLAG_EN
            chk("zero_hold", 32'(bus.zero), 32'(exp_hold == '0));
`endif
         end
      end
   end

   task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] o, logic [W-1:0] r);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.op    = o;
      q.push_back('{r, cyc + 1 + W});
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * W && q.size() > 0; i++) @(negedge clk);
      chk("drain_pending", q.size(), 0);
      @(negedge clk);
   endtask

   task automatic single(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] o, logic [W-1:0] r);
      @(negedge clk);
      issue(a, b, o, r);
      @(negedge clk);
      bus.start = 1'b0;
      drain();
   endtask

   task automatic b2b(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] o1, logic [1:0] o2);
      @(negedge clk);
      issue(a, b, o1, ref_op(a, b, o1));
      repeat (W + 1) @(negedge clk);
      issue(a, b, o2, ref_op(a, b, o2));
      @(negedge clk);
      bus.start = 1'b0;
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] a, b;
      logic [1:0]   o;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.op    = 2'b00;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_result", 32'(bus.result), 32'd0);
      chk("reset_lu_control", 32'(bus.lu_control), 32'd0);
      reset = 1'b0;
      single(8'hCA, 8'hA6, 2'b00, 8'h82);
      single(8'hCA, 8'hA6, 2'b01, 8'hEE);
      single(8'hCA, 8'hA6, 2'b10, 8'h11);
      single(8'hCA, 8'hA6, 2'b11, 8'h6C);
      b2b(8'hCA, 8'hA6, 2'b00, 2'b11);
      // start pulse and operand change mid-run must not disturb the active op
      @(negedge clk);
      issue(8'hCA, 8'hA6, 2'b01, 8'hEE);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 8'h00;
      bus.op    = 2'b00;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      // reset in the 4th run cycle aborts without a done pulse
      @(negedge clk);
      issue(8'hCA, 8'hA6, 2'b11, 8'h6C);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      q.delete();
      exp_hold = '0;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      repeat (2 * W) @(negedge clk);
`ifdef LOGSEQ_ZFLAG_EN
      single(8'hF0, 8'h0F, 2'b00, 8'h00);
      single(8'hF0, 8'h0F, 2'b01, 8'hFF);
`endif
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         o = 2'($urandom_range(3));
         if (i % 3 == 0)
            b2b(a, b, o, 2'($urandom_range(3)));
         else
            single(a, b, o, ref_op(a, b, o));
      end
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
